activation_unit: RTL
====================

# activation_unit

Streaming, parametrised activation block that applies ReLU, leaky ReLU, clipped ReLU or bypass to a fixed-point vector. It processes `LANES` elements per cycle over several beats. It accepts a whole vector through a valid/ready handshake and returns the activated vector through a second valid/ready handshake. It sits between the dense/accumulate stage and the next layer's input buffer and replaces the purely combinational ReLU stage.

## Interface
- `VEC_SIZE`, 64: elements per vector.
- `DATA_WIDTH`, 16: signed element width, two's complement.
- `FIXED_PNT`, 8: fractional bits. Informational only; all arithmetic is format-preserving.
- `LANES`, 8: elements processed per cycle. `VEC_SIZE % LANES == 0` is required; an elaboration error fires otherwise.
- `LEAK_SHIFT`, 3: leaky slope is 2^-LEAK_SHIFT. Range 1..DATA_WIDTH-1.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `vec_in`, `mode` and `clip_val` are valid.
- `in_ready` output, 1: block can accept a vector.
- `vec_in` input, signed [DATA_WIDTH-1:0] x VEC_SIZE: input vector.
- `mode` input, 2: 0 = ReLU, 1 = leaky ReLU, 2 = clipped ReLU, 3 = bypass.
- `clip_val` input, [DATA_WIDTH-2:0]: non-negative clip ceiling, same fixed-point scaling as the data.
- `out_valid` output, 1: `vec_out` holds a complete result.
- `out_ready` input, 1: downstream accepts the result.
- `vec_out` output, signed [DATA_WIDTH-1:0] x VEC_SIZE: registered result vector.
- `busy` output, 1: high in BUSY or DONE.

## Operation
- `NB = VEC_SIZE/LANES` beats per vector. Beat counter width is `$clog2(NB)`, minimum 1.
- State IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: capture `vec_in`, `mode` and `clip_val` into internal registers, clear the beat counter, go to BUSY.
- State BUSY:
  - Each cycle, lanes compute elements `[beat*LANES +: LANES]` from the captured vector and write them into the `vec_out` register.
  - Beat counter increments each cycle.
  - After beat NB-1, go to DONE.
- State DONE:
  - `out_valid = 1`; `vec_out` is held stable.
  - On `out_ready`, go to IDLE.
- Per-element function, for x = element:
  - ReLU: `x > 0 ? x : 0`.
  - Leaky: `x > 0 ? x : (x >>> LEAK_SHIFT)`. This is an arithmetic shift, rounding toward negative infinity; it never overflows.
  - Clipped: `x <= 0 ? 0 : (x > clip_val ? clip_val : x)`, where `clip_val` is zero-extended to DATA_WIDTH.
  - Bypass: `x`.
- `mode`, `clip_val` and `vec_in` changes after acceptance have no effect on the vector in flight.
- Mode and clip are per vector, latched at acceptance.
- `vec_out` elements not yet written in BUSY hold stale values. Consumers must sample only while `out_valid` is high.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE, beat counter 0, `vec_out` all 0.
  - `out_valid = 0`, `busy = 0`.
  - `in_ready` is forced low while `rst_n` is low and goes high on the first cycle after release.
- Latency: if a vector is accepted at edge k, beats are written on edges k+1 through k+NB and `out_valid` rises after edge k+NB. With defaults, `out_valid` is high 8 cycles after acceptance.
- `out_valid` stays high and `vec_out` stays stable until the edge where `out_valid && out_ready` is sampled. `out_valid` falls after that edge.
- `in_ready` is high only in IDLE, so it is low in BUSY and DONE. The earliest next acceptance is the cycle after the output handshake.
  - Maximum throughput is one vector per NB+2 cycles.
  - A stuck-high `out_ready` still gives NB+2.
- `in_valid` asserted in BUSY or DONE is ignored and not queued.
- `out_ready` high while `out_valid` is low is ignored.
- Reset asserted mid-BUSY or mid-DONE aborts the vector: no partial `out_valid` and outputs are zeroed. After release the block is in IDLE.
- `NB == 1` (`LANES == VEC_SIZE`): BUSY lasts one cycle.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n` low for 3 cycles, then release.
  - Required: `vec_out` all 0x0000, `out_valid = 0`, `busy = 0`; `in_ready` low during reset and high the cycle after release.
- ReLU, Q8.8, defaults:
  - Stimulus: `vec_in[i]` alternates 0x0180 (1.5), 0xFE00 (-2.0), 0x0000, 0x8000; `mode = 0`.
  - Required: outputs 0x0180, 0x0000, 0x0000, 0x0000; `out_valid` exactly 8 cycles after acceptance.
- Leaky ReLU, same vector, `mode = 1`:
  - Required: 0x0180, 0xFFC0, 0x0000, 0xF000.
- Clipped ReLU, `clip_val = 0x0600` (6.0), `mode = 2`:
  - Stimulus: elements 0x0700, 0x0600, 0x0100, 0xFF00.
  - Required: 0x0600, 0x0600, 0x0100, 0x0000.
- Backpressure and input isolation:
  - Stimulus: hold `out_ready` low for 5 cycles after `out_valid`; meanwhile drive a new `vec_in` and `mode` with `in_valid` high.
  - Required: `vec_out` stable; second vector not accepted until the cycle after the handshake; first result unaffected.
- Reset mid-operation:
  - Stimulus: assert `rst_n` low at beat 4 of a vector.
  - Required: immediate `vec_out` 0x0000 and `out_valid = 0`; the next vector after release completes correctly in `mode = 3` (bypass) with output equal to input.

Source files
------------

// File: rtl/activation_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | activation_unit                                                            |
// | Streaming vector activation (ReLU / leaky / clipped / bypass), LANES/beat  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module activation_unit #(
  parameter int VEC_SIZE   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int LANES      = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  vec_in,
  input  logic [1:0]                           mode,
  input  logic [DATA_WIDTH-2:0]                clip_val,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  vec_out,
  output logic                                 busy
);

  localparam int c_NB = VEC_SIZE / LANES;
  localparam int c_BW = (c_NB > 1) ? $clog2(c_NB) : 1;

  localparam logic [1:0] c_MODE_RELU  = 2'd0;
  localparam logic [1:0] c_MODE_LEAKY = 2'd1;
  localparam logic [1:0] c_MODE_CLIP  = 2'd2;

  if (VEC_SIZE % LANES != 0) begin : g_bad_lanes
    $error("activation_unit: VEC_SIZE must be a multiple of LANES");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > DATA_WIDTH - 1) begin : g_bad_leak
    $error("activation_unit: LEAK_SHIFT out of range 1..DATA_WIDTH-1");
  end
  if (FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_fixed
    $error("activation_unit: FIXED_PNT out of range 0..DATA_WIDTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                                         r_rdy_en;
  logic [c_BW-1:0]                              r_beat;
  logic [c_NB-1:0][LANES-1:0][DATA_WIDTH-1:0]   r_vec;
  logic [c_NB-1:0][LANES-1:0][DATA_WIDTH-1:0]   r_out;
  logic [1:0]                                   r_mode;
  logic [DATA_WIDTH-2:0]                        r_clip;

  logic                                         w_accept;
  logic                                         w_last_beat;
  logic [LANES-1:0][DATA_WIDTH-1:0]             w_beat_in;
  logic [LANES-1:0][DATA_WIDTH-1:0]             w_beat_res;
  logic signed [DATA_WIDTH-1:0]                 w_clip_ext;

  // in_ready stays low until the first edge after reset release
  assign in_ready    = r_rdy_en && (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign vec_out     = r_out;
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_beat == c_BW'(c_NB - 1));
  assign w_beat_in   = r_vec[r_beat];
  assign w_clip_ext  = $signed({1'b0, r_clip});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last_beat) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] w_x;
    logic signed [DATA_WIDTH-1:0] w_y;
    logic                         w_pos;

    assign w_x   = w_beat_in[l];
    assign w_pos = !w_x[DATA_WIDTH-1] && (|w_x);

    always_comb begin
      w_y = w_x;
      case (r_mode)
        c_MODE_RELU:  w_y = w_pos ? w_x : '0;
        c_MODE_LEAKY: w_y = w_pos ? w_x : (w_x >>> LEAK_SHIFT);
        c_MODE_CLIP:  w_y = !w_pos ? '0 : ((w_x > w_clip_ext) ? w_clip_ext : w_x);
        default:      w_y = w_x;
      endcase
    end

    assign w_beat_res[l] = w_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_beat   <= '0;
      r_vec    <= '0;
      r_out    <= '0;
      r_mode   <= '0;
      r_clip   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_vec  <= vec_in;
        r_mode <= mode;
        r_clip <= clip_val;
        r_beat <= '0;
      end else if (r_state == S_BUSY) begin
        // untouched beats keep their previous contents until overwritten
        r_out[r_beat] <= w_beat_res;
        r_beat        <= r_beat + c_BW'(1);
      end
    end
  end

endmodule
`default_nettype wire
